adas_sensor_monitor: RTL and testbench



---
 rtl/adas_sensor_monitor_if.sv | 29 ++
 rtl/adas_sensor_monitor.sv | 155 +++++++++++++++
 tb/tb_adas_sensor_monitor.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adas_sensor_monitor_if.sv
// Signal bundle between the ADAS sensor monitor and its environment.
// master side drives raw sensor inputs and heartbeats; slave is the monitor.
// Outputs feed the downstream adas brake-decision module.
interface adas_sensor_monitor_if;
  logic       driver_break_raw;
  logic       camera_raw;
  logic       radar_raw;
  logic       camera_heartbeat;
  logic       radar_heartbeat;
  logic       error_clear;
  logic       driver_break;
  logic       camera;
  logic       radar;
  logic       adas_error;
  logic [1:0] state;
  logic [1:0] fault_code;

  modport master (
    output driver_break_raw, camera_raw, radar_raw,
    output camera_heartbeat, radar_heartbeat, error_clear,
    input  driver_break, camera, radar, adas_error, state, fault_code
  );

  modport slave (
    input  driver_break_raw, camera_raw, radar_raw,
    input  camera_heartbeat, radar_heartbeat, error_clear,
    output driver_break, camera, radar, adas_error, state, fault_code
  );
endinterface

// File: rtl/adas_sensor_monitor.sv
// Debounces pedal/camera/radar, watches sensor heartbeats and plausibility, latches faults.
// Latency: outputs registered; a debounced change appears DEBOUNCE_CYCLES edges after the first differing sample.
// Backpressure: none; every input is sampled on every rising clock edge.
module adas_sensor_monitor #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int HEARTBEAT_TIMEOUT = 8,
  parameter int MISMATCH_CYCLES   = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  adas_sensor_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HB_MAX  = 8'(HEARTBEAT_TIMEOUT);
  localparam logic [7:0] MM_MAX  = 8'(MISMATCH_CYCLES);

  // Index 0 pedal, 1 camera, 2 radar.
  logic [2:0] raw;
  logic [2:0] deb_q, deb_d;
  logic [3:0] dcnt_q [3];
  logic [3:0] dcnt_d [3];

  // Index 0 camera, 1 radar.
  logic [1:0] hb;
  logic [7:0] wd_q [2];
  logic [7:0] wd_d [2];
  logic [1:0] seen_q, seen_d;
  logic [1:0] timeout;
  logic       clr_seen;

  logic [7:0] mm_q, mm_d;
  logic       mismatch;

  state_e     state_q, state_d;
  logic [1:0] fault_code_q, fault_code_d;
  logic       driver_break_q, driver_break_d;
  logic       camera_q, camera_d;
  logic       radar_q, radar_d;
  logic       adas_error_q, adas_error_d;

  assign raw      = {bus.radar_raw, bus.camera_raw, bus.driver_break_raw};
  assign hb       = {bus.radar_heartbeat, bus.camera_heartbeat};
  assign mismatch = (mm_q == MM_MAX);

  // Debouncers: adopt raw only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = 4'd0;
      if (raw[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_LAST) deb_d[i] = raw[i];
        else                      dcnt_d[i] = dcnt_q[i] + 4'd1;
      end
    end
  end

  // Supervisory FSM next state and sticky fault cause.
  always_comb begin
    for (int i = 0; i < 2; i++) timeout[i] = (wd_q[i] == HB_MAX);
    state_d      = state_q;
    fault_code_d = fault_code_q;
    clr_seen     = 1'b0;
    case (state_q)
      ST_STARTUP: if (&seen_q && ~|timeout) state_d = ST_RUN;
      ST_RUN: begin
        if (|timeout || mismatch) begin
          state_d      = ST_FAULT;
          fault_code_d = fault_code_q | {mismatch, |timeout};
        end
      end
      ST_FAULT: begin
        // Acknowledge only honoured once both sensors are alive again.
        if (bus.error_clear && ~|timeout) begin
          state_d      = ST_STARTUP;
          fault_code_d = 2'b00;
          clr_seen     = 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // Heartbeat watchdogs; a pulse on the limit edge still wins. Leaving FAULT forgets liveness.
  always_comb begin
    seen_d = seen_q;
    for (int i = 0; i < 2; i++) begin
      if (hb[i]) begin
        wd_d[i]   = 8'd0;
        seen_d[i] = 1'b1;
      end else begin
        wd_d[i] = (wd_q[i] == HB_MAX) ? wd_q[i] : wd_q[i] + 8'd1;
      end
    end
    if (clr_seen) seen_d = 2'b00;
  end

  // Plausibility: count consecutive RUN cycles with camera and radar disagreeing.
  always_comb begin
    mm_d = 8'd0;
    if (state_q == ST_RUN && deb_q[1] != deb_q[2])
      mm_d = (mm_q == MM_MAX) ? mm_q : mm_q + 8'd1;
  end

  // Outputs follow the next state so they change on the same edge as the FSM.
  always_comb begin
    driver_break_d = deb_d[0];
    camera_d       = (state_d == ST_RUN) && deb_d[1];
    radar_d        = (state_d == ST_RUN) && deb_d[2];
    adas_error_d   = (state_d != ST_RUN);
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      deb_q          <= 3'b000;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= 4'd0;
      for (int i = 0; i < 2; i++) wd_q[i]   <= 8'd0;
      seen_q         <= 2'b00;
      mm_q           <= 8'd0;
      state_q        <= ST_STARTUP;
      fault_code_q   <= 2'b00;
      driver_break_q <= 1'b0;
      camera_q       <= 1'b0;
      radar_q        <= 1'b0;
      adas_error_q   <= 1'b1;
    end else begin
      deb_q          <= deb_d;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
      for (int i = 0; i < 2; i++) wd_q[i]   <= wd_d[i];
      seen_q         <= seen_d;
      mm_q           <= mm_d;
      state_q        <= state_d;
      fault_code_q   <= fault_code_d;
      driver_break_q <= driver_break_d;
      camera_q       <= camera_d;
      radar_q        <= radar_d;
      adas_error_q   <= adas_error_d;
    end
  end

  assign bus.driver_break = driver_break_q;
  assign bus.camera       = camera_q;
  assign bus.radar        = radar_q;
  assign bus.adas_error   = adas_error_q;
  assign bus.state        = state_q;
  assign bus.fault_code   = fault_code_q;

endmodule

// File: tb/tb_adas_sensor_monitor.sv
// Self-checking bench for adas_sensor_monitor: directed scenarios plus random stimulus.
// Every cycle the DUT outputs are compared against a behavioural model of the sensor rules.
// Heartbeats come from a simple per-sensor period scheduler or from random draws.
module tb_adas_sensor_monitor;
  localparam int DC = 4;
  localparam int HT = 8;
  localparam int MC = 6;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  adas_sensor_monitor_if bus();

  adas_sensor_monitor #(
    .DEBOUNCE_CYCLES(DC), .HEARTBEAT_TIMEOUT(HT), .MISMATCH_CYCLES(MC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Heartbeat scheduler: period 0 means silent.
  int cam_per = 0, rad_per = 0, cam_cd = 0, rad_cd = 0;

  // Reference model (sensor index: 0 pedal, 1 camera, 2 radar; heartbeat 0 camera, 1 radar).
  int m_deb  [3];
  int m_dcnt [3];
  int m_wd   [2];
  int m_seen [2];
  int m_mm, m_st, m_fc;

  task automatic model_edge();
    int raw [3];
    int hbv [2];
    int to_any, mmf, nst, nfc, clr;
    raw[0] = int'(bus.driver_break_raw);
    raw[1] = int'(bus.camera_raw);
    raw[2] = int'(bus.radar_raw);
    hbv[0] = int'(bus.camera_heartbeat);
    hbv[1] = int'(bus.radar_heartbeat);
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin m_deb[i] = 0; m_dcnt[i] = 0; end
      for (int i = 0; i < 2; i++) begin m_wd[i] = 0; m_seen[i] = 0; end
      m_mm = 0; m_st = 0; m_fc = 0;
      return;
    end
    to_any = (m_wd[0] == HT || m_wd[1] == HT) ? 1 : 0;
    mmf    = (m_mm == MC) ? 1 : 0;
    nst = m_st; nfc = m_fc; clr = 0;
    if (m_st == 0 && m_seen[0] == 1 && m_seen[1] == 1 && to_any == 0) nst = 1;
    if (m_st == 1 && (to_any == 1 || mmf == 1)) begin
      nst = 2;
      nfc = m_fc | to_any | (mmf * 2);
    end
    if (m_st == 2 && bus.error_clear && to_any == 0) begin
      nst = 0; nfc = 0; clr = 1;
    end
    if (m_st == 1 && m_deb[1] != m_deb[2]) m_mm = (m_mm + 1 > MC) ? MC : m_mm + 1;
    else m_mm = 0;
    for (int i = 0; i < 2; i++) begin
      if (hbv[i] == 1) begin m_wd[i] = 0; m_seen[i] = 1; end
      else m_wd[i] = (m_wd[i] + 1 > HT) ? HT : m_wd[i] + 1;
      if (clr == 1) m_seen[i] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (raw[i] != m_deb[i]) begin
        m_dcnt[i]++;
        if (m_dcnt[i] == DC) begin m_deb[i] = raw[i]; m_dcnt[i] = 0; end
      end else m_dcnt[i] = 0;
    end
    m_st = nst; m_fc = nfc;
  endtask

  // Packed view {driver_break, camera, radar, adas_error, state, fault_code}.
  function automatic logic [7:0] obs();
    return {bus.driver_break, bus.camera, bus.radar, bus.adas_error, bus.state, bus.fault_code};
  endfunction

  function automatic logic [7:0] exp_out();
    logic [7:0] e;
    e[7]   = (m_deb[0] != 0);
    e[6]   = (m_st == 1) && (m_deb[1] != 0);
    e[5]   = (m_st == 1) && (m_deb[2] != 0);
    e[4]   = (m_st != 1);
    e[3:2] = 2'(m_st);
    e[1:0] = 2'(m_fc);
    return e;
  endfunction

  // Drive scheduled heartbeats, clock one edge, advance the model, settle.
  task automatic tick();
    if (cam_per > 0) begin
      bus.camera_heartbeat = (cam_cd == 0);
      cam_cd = (cam_cd == 0) ? cam_per - 1 : cam_cd - 1;
    end
    if (rad_per > 0) begin
      bus.radar_heartbeat = (rad_cd == 0);
      rad_cd = (rad_cd == 0) ? rad_per - 1 : rad_cd - 1;
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_hb(input int cp, input int cfirst, input int rp, input int rfirst);
    cam_per = cp; cam_cd = cfirst;
    rad_per = rp; rad_cd = rfirst;
    if (cp == 0) bus.camera_heartbeat = 1'b0;
    if (rp == 0) bus.radar_heartbeat  = 1'b0;
  endtask

  task automatic go_run(input string tag);
    int n = 0;
    while (bus.state !== 2'd1 && n < 40) begin
      tick(); n++;
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL %s_to_run got=%b exp=%b", tag, obs(), exp_out()); errors++;
      end
    end
    checks++;
    if (bus.state !== 2'd1) begin
      $display("FAIL %s_reach_run got state=%0d exp=1", tag, bus.state); errors++;
    end
  endtask

  task automatic recover(input string tag);
    int n = 0;
    bus.camera_raw = 1'b0; bus.radar_raw = 1'b0;
    set_hb(4, 0, 4, 1);
    for (int i = 0; i < DC + 1; i++) tick();
    bus.error_clear = 1'b1;
    while (bus.state !== 2'd0 && n < 30) begin
      tick(); n++;
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL %s_clear got=%b exp=%b", tag, obs(), exp_out()); errors++;
      end
    end
    bus.error_clear = 1'b0;
    go_run(tag);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.driver_break_raw = 1'b0; bus.camera_raw = 1'b0; bus.radar_raw = 1'b0;
    bus.error_clear = 1'b0;
    set_hb(0, 0, 0, 0);
    tick(); tick();
    checks++;
    if (obs() !== 8'b0001_0000) begin
      $display("FAIL reset_values got=%b exp=%b", obs(), 8'b0001_0000); errors++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_startup();
    set_hb(4, 2, 4, 2);
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL startup cyc=%0d got=%b exp=%b", c, obs(), exp_out()); errors++;
      end
    end
    checks++;
    if (bus.state !== 2'd1 || bus.adas_error !== 1'b0) begin
      $display("FAIL startup_run got state=%0d err=%b exp state=1 err=0", bus.state, bus.adas_error);
      errors++;
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (obs() !== 8'b0001_0000) begin
      $display("FAIL midrun_reset got=%b exp=%b", obs(), 8'b0001_0000); errors++;
    end
    go_run("after_reset");
  endtask

  task automatic test_debounce();
    logic [7:0] pat;
    pat = 8'b1111_0111;  // applied LSB first: high x3, low, high x4
    for (int i = 0; i < 8; i++) begin
      bus.camera_raw = pat[i];
      tick();
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL debounce step=%0d got=%b exp=%b", i, obs(), exp_out()); errors++;
      end
      checks++;
      if (bus.camera !== (i == 7)) begin
        $display("FAIL debounce_camera step=%0d got=%b exp=%b", i, bus.camera, (i == 7)); errors++;
      end
    end
    bus.camera_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL debounce_fall step=%0d got=%b exp=%b", i, obs(), exp_out()); errors++;
      end
    end
  endtask

  task automatic test_hb_timeout();
    int n = 0;
    set_hb(4, cam_cd, 0, 0);
    while (bus.state !== 2'd2 && n < 30) begin
      tick(); n++;
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL hb_timeout got=%b exp=%b", obs(), exp_out()); errors++;
      end
    end
    checks++;
    if ({bus.state, bus.fault_code, bus.adas_error, bus.camera, bus.radar} !== 7'b10_01_100) begin
      $display("FAIL hb_timeout_fault got=%b exp=%b",
               {bus.state, bus.fault_code, bus.adas_error, bus.camera, bus.radar}, 7'b10_01_100);
      errors++;
    end
    bus.driver_break_raw = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.driver_break_raw = 1'b0;
    checks++;
    if (bus.driver_break !== 1'b1) begin
      $display("FAIL fault_brake got=%b exp=1", bus.driver_break); errors++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL fault_brake_fall got=%b exp=%b", obs(), exp_out()); errors++;
      end
    end
  endtask

  task automatic test_clear();
    int n = 0;
    bus.error_clear = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.error_clear = 1'b0;
    checks++;
    if (bus.state !== 2'd2 || bus.fault_code !== 2'b01) begin
      $display("FAIL clear_ignored got state=%0d code=%b exp state=2 code=01", bus.state, bus.fault_code);
      errors++;
    end
    set_hb(4, cam_cd, 4, 0);
    tick(); tick();
    bus.error_clear = 1'b1;
    while (bus.state !== 2'd0 && n < 20) begin
      tick(); n++;
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL clear got=%b exp=%b", obs(), exp_out()); errors++;
      end
    end
    bus.error_clear = 1'b0;
    checks++;
    if (bus.state !== 2'd0 || bus.fault_code !== 2'b00 || bus.adas_error !== 1'b1) begin
      $display("FAIL clear_startup got state=%0d code=%b err=%b exp 0 00 1",
               bus.state, bus.fault_code, bus.adas_error);
      errors++;
    end
    go_run("clear");
  endtask

  task automatic test_mismatch();
    int n = 0;
    bus.camera_raw = 1'b1; bus.radar_raw = 1'b0;
    while (bus.state !== 2'd2 && n < 30) begin
      tick(); n++;
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL mismatch got=%b exp=%b", obs(), exp_out()); errors++;
      end
    end
    checks++;
    if (bus.state !== 2'd2 || bus.fault_code !== 2'b10) begin
      $display("FAIL mismatch_fault got state=%0d code=%b exp state=2 code=10", bus.state, bus.fault_code);
      errors++;
    end
    checks++;
    if (n != DC + MC + 1) begin
      $display("FAIL mismatch_latency got=%0d exp=%0d", n, DC + MC + 1); errors++;
    end
    recover("mismatch");
  endtask

  task automatic test_hb_edge();
    int n = 0;
    set_hb(4, cam_cd, 8, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (bus.state !== 2'd1 || obs() !== exp_out()) begin
        $display("FAIL hb_edge cyc=%0d got=%b exp=%b (state must stay 1)", i, obs(), exp_out());
        errors++;
      end
    end
    set_hb(4, cam_cd, 9, rad_cd);
    while (bus.state !== 2'd2 && n < 30) begin
      tick(); n++;
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL hb_late got=%b exp=%b", obs(), exp_out()); errors++;
      end
    end
    checks++;
    if (bus.state !== 2'd2 || bus.fault_code !== 2'b01) begin
      $display("FAIL hb_late_fault got state=%0d code=%b exp state=2 code=01", bus.state, bus.fault_code);
      errors++;
    end
    recover("hb_edge");
  endtask

  task automatic test_random();
    set_hb(0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 3) == 0) bus.driver_break_raw = ~bus.driver_break_raw;
      if ($urandom_range(0, 5) == 0) bus.camera_raw = ~bus.camera_raw;
      if ($urandom_range(0, 5) == 0) bus.radar_raw  = ~bus.radar_raw;
      bus.camera_heartbeat = ($urandom_range(0, 4) == 0);
      bus.radar_heartbeat  = ($urandom_range(0, 4) == 0);
      bus.error_clear      = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (obs() !== exp_out()) begin
        $display("FAIL random cyc=%0d got=%b exp=%b", c, obs(), exp_out()); errors++;
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_debounce();
    test_hb_timeout();
    test_clear();
    test_mismatch();
    test_hb_edge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
